// File: rtl/frame_relay_if.sv
// frame_relay_if: byte-stream bus of the frame relay.
// The receive side (rxd/rx_dv) is driven by the master and sampled by the relay.
// The transmit side (txd/tx_en) is driven by the relay and observed by the master.
interface frame_relay_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] rxd;
  logic              rx_dv;
  logic [DATA_W-1:0] txd;
  logic              tx_en;

  modport master (
    output rxd,
    output rx_dv,
    input  txd,
    input  tx_en
  );

  modport slave (
    input  rxd,
    input  rx_dv,
    output txd,
    output tx_en
  );
endinterface

// File: rtl/frame_relay.sv
// frame_relay: store-and-forward relay for the rxd/rx_dv -> txd/tx_en byte stream.
//
// Each received frame is a contiguous rx_dv-high run. It is written into a FIFO.
// A frame is released to tx only once it is complete, so tx never shows a partial frame.
// A frame that overflows the FIFO is rolled back and dropped whole.
// At least IFG idle cycles separate consecutive transmitted frames.
//
// Optional feature macro: FRAME_RELAY_STATS_EN.
//   Defined:   frame_cnt and drop_cnt count forwarded and dropped frames.
//   Undefined: no counter registers exist, and both outputs are tied to zero.
module frame_relay #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int IFG    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  frame_relay_if.slave bus,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int GW = $clog2(IFG + 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_FRAME = 2'd1,
    RX_DROP  = 2'd2
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_GAP  = 2'd2
  } tx_state_t;

  // Storage and pointers
  logic [DATA_W-1:0] r_mem [0:DEPTH-1];
  logic              r_eof [0:DEPTH-1];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_commit_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_pend;
  rx_state_t         r_rx_state;
  tx_state_t         r_tx_state;
  logic [GW-1:0]     r_gap;
  logic [DATA_W-1:0] r_txd;
  logic              r_tx_en;

  // Combinational decisions
  rx_state_t         w_rx_next;
  tx_state_t         w_tx_next;
  logic [PW-1:0]     w_used;
  logic              w_full;
  logic              w_avail;
  logic              w_wr_en;
  logic              w_commit;
  logic              w_rollback;
  logic              w_emit;
  logic              w_eof_sent;
  logic [AW-1:0]     w_wr_idx;
  logic [AW-1:0]     w_last_idx;
  logic [AW-1:0]     w_rd_idx;
  logic              w_rd_eof;
  logic [DATA_W-1:0] w_rd_data;

  assign w_used     = r_wr_ptr - r_rd_ptr;
  assign w_full     = (w_used == PW'(DEPTH));
  assign w_avail    = (r_rd_ptr != r_commit_ptr);
  assign w_wr_idx   = r_wr_ptr[AW-1:0];
  assign w_last_idx = r_wr_ptr[AW-1:0] - AW'(1);
  assign w_rd_idx   = r_rd_ptr[AW-1:0];
  assign w_rd_eof   = r_eof[w_rd_idx];
  assign w_rd_data  = r_mem[w_rd_idx];
  assign w_eof_sent = w_emit & w_rd_eof;

  assign bus.txd   = r_txd;
  assign bus.tx_en = r_tx_en;

  // Receive decision: write, commit at frame end, or roll back and drop on overflow
  always_comb begin
    w_rx_next  = r_rx_state;
    w_wr_en    = 1'b0;
    w_commit   = 1'b0;
    w_rollback = 1'b0;
    case (r_rx_state)
      RX_IDLE, RX_FRAME: begin
        if (bus.rx_dv) begin
          if (w_full) begin
            w_rollback = 1'b1;
            w_rx_next  = RX_DROP;
          end else begin
            w_wr_en   = 1'b1;
            w_rx_next = RX_FRAME;
          end
        end else begin
          w_commit  = (r_rx_state == RX_FRAME);
          w_rx_next = RX_IDLE;
        end
      end
      RX_DROP: begin
        if (bus.rx_dv) begin
          w_rx_next = RX_DROP;
        end else begin
          w_rx_next = RX_IDLE;
        end
      end
      default: begin
        w_rx_next = RX_IDLE;
      end
    endcase
  end

  // Receive state, write pointer and commit pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_state   <= RX_IDLE;
      r_wr_ptr     <= {PW{1'b0}};
      r_commit_ptr <= {PW{1'b0}};
    end else begin
      r_rx_state <= w_rx_next;
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end else if (w_rollback) begin
        r_wr_ptr <= r_commit_ptr;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_commit) begin
        r_commit_ptr <= r_wr_ptr;
      end else begin
        r_commit_ptr <= r_commit_ptr;
      end
    end
  end

  // FIFO data array; contents are only read after being written, so no reset is needed
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= bus.rxd;
    end
  end

  // End-of-frame marks: cleared on write, set on the last byte at commit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_eof[i] <= 1'b0;
      end
    end else if (w_wr_en) begin
      r_eof[w_wr_idx] <= 1'b0;
    end else if (w_commit) begin
      r_eof[w_last_idx] <= 1'b1;
    end else begin
      r_eof[w_wr_idx] <= r_eof[w_wr_idx];
    end
  end

  // Transmit FSM next state: start a committed frame, stream it, then hold the gap
  always_comb begin
    w_tx_next = r_tx_state;
    w_emit    = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if ((r_pend != {PW{1'b0}}) && (r_gap >= GW'(IFG)) && w_avail) begin
          w_emit    = 1'b1;
          w_tx_next = w_rd_eof ? TX_GAP : TX_SEND;
        end else begin
          w_tx_next = TX_IDLE;
        end
      end
      TX_SEND: begin
        if (w_avail) begin
          w_emit    = 1'b1;
          w_tx_next = w_rd_eof ? TX_GAP : TX_SEND;
        end else begin
          w_tx_next = TX_SEND;
        end
      end
      TX_GAP: begin
        if (r_gap >= GW'(IFG - 1)) begin
          w_tx_next = TX_IDLE;
        end else begin
          w_tx_next = TX_GAP;
        end
      end
      default: begin
        w_tx_next = TX_IDLE;
      end
    endcase
  end

  // Transmit state, read pointer and registered tx outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_rd_ptr   <= {PW{1'b0}};
      r_txd      <= {DATA_W{1'b0}};
      r_tx_en    <= 1'b0;
    end else begin
      r_tx_state <= w_tx_next;
      r_tx_en    <= w_emit;
      if (w_emit) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
        r_txd    <= w_rd_data;
      end else begin
        r_rd_ptr <= r_rd_ptr;
        r_txd    <= r_txd;
      end
    end
  end

  // Idle-cycle counter since the last frame; saturates at IFG, restarts on end of frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gap <= GW'(IFG);
    end else if (w_eof_sent) begin
      r_gap <= {GW{1'b0}};
    end else if (!w_emit && (r_gap < GW'(IFG))) begin
      r_gap <= r_gap + GW'(1);
    end else begin
      r_gap <= r_gap;
    end
  end

  // Count of complete frames waiting for or in transmission
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend <= {PW{1'b0}};
    end else begin
      case ({w_commit, w_eof_sent})
        2'b10:   r_pend <= r_pend + PW'(1);
        2'b01:   r_pend <= r_pend - PW'(1);
        default: r_pend <= r_pend;
      endcase
    end
  end

`ifdef FRAME_RELAY_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_drop_cnt;
  logic        w_drop_done;

  assign w_drop_done = (r_rx_state == RX_DROP) && !bus.rx_dv;
  assign frame_cnt   = r_frame_cnt;
  assign drop_cnt    = r_drop_cnt;

  // Statistics: forwarded frames on the last tx byte, dropped frames at rx frame end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_cnt <= 16'd0;
      r_drop_cnt  <= 16'd0;
    end else begin
      if (w_eof_sent) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end else begin
        r_frame_cnt <= r_frame_cnt;
      end
      if (w_drop_done) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end else begin
        r_drop_cnt <= r_drop_cnt;
      end
    end
  end
`else
  assign frame_cnt = 16'd0;
  assign drop_cnt  = 16'd0;
`endif

endmodule
